// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes and register-slave FSM state types.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WIdle,
    WCommit,
    WResp
  } w_state_e;

  typedef enum logic [0:0] {
    RIdle,
    RResp
  } r_state_e;

endpackage

// File: rtl/axi_lite_wr_capture.sv
// Independent AW/W hold registers with ready generation; flags when both halves of a write
// are present so the top can commit.
module axi_lite_wr_capture #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_WIDTH-1:0]     aw_addr,
  input  logic                      aw_valid,
  output logic                      aw_ready,
  input  logic [DATA_WIDTH-1:0]     w_data,
  input  logic [DATA_WIDTH/8-1:0]   w_strb,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic                      b_valid,
  input  logic                      clear,
  output logic                      both_captured,
  output logic [ADDR_WIDTH-1:0]     held_addr,
  output logic [DATA_WIDTH-1:0]     held_data,
  output logic [DATA_WIDTH/8-1:0]   held_strb
);

  logic                    aw_held_q, w_held_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH/8-1:0] strb_q;
  logic                    aw_fire, w_fire;

  assign aw_ready = !aw_held_q && !b_valid;
  assign w_ready  = !w_held_q && !b_valid;
  assign aw_fire  = aw_valid && aw_ready;
  assign w_fire   = w_valid && w_ready;

  // True when both holds are set or being set at this edge, so commit starts one cycle later.
  assign both_captured = (aw_held_q || aw_fire) && (w_held_q || w_fire);

  assign held_addr = addr_q;
  assign held_data = data_q;
  assign held_strb = strb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      if (clear) begin
        aw_held_q <= 1'b0;
      end else if (aw_fire) begin
        aw_held_q <= 1'b1;
      end
      if (clear) begin
        w_held_q <= 1'b0;
      end else if (w_fire) begin
        w_held_q <= 1'b1;
      end
      if (aw_fire) addr_q <= aw_addr;
      if (w_fire) begin
        data_q <= w_data;
        strb_q <= w_strb;
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register-file slave with per-register write pulses.
// Define AXIL_SLV_SLVERR_EN to return SLVERR for out-of-range accesses (OKAY otherwise).
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned          NUM_REGS   = 8,
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [1:0]                     b_resp,
  output logic                           b_valid,
  input  logic                           b_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic                           ar_valid,
  output logic                           ar_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);

  localparam int unsigned StrbW     = DATA_WIDTH / 8;
  localparam int unsigned ByteShift = $clog2(StrbW);
  // One bit wider than needed so offsets just past the last register decode as out of range.
  localparam int unsigned IdxW      = $clog2(NUM_REGS) + 1;

`ifdef AXIL_SLV_SLVERR_EN
  localparam logic [1:0] RangeErrResp = RESP_SLVERR;
`else
  localparam logic [1:0] RangeErrResp = RESP_OKAY;
`endif

  logic [ADDR_WIDTH-1:0]               wr_addr;
  logic [DATA_WIDTH-1:0]               wr_data;
  logic [StrbW-1:0]                    wr_strb;
  logic                                both_captured;
  logic                                commit;
  w_state_e                            w_state_q, w_state_d;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 pulse_q, pulse_d;
  logic [1:0]                          b_resp_q;
  logic [IdxW-1:0]                     wr_idx, rd_idx;
  logic                                wr_in_range, rd_in_range;
  r_state_e                            r_state_q, r_state_d;
  logic                                ar_fire;
  logic [DATA_WIDTH-1:0]               rd_word, r_data_q;
  logic [1:0]                          r_resp_q;
  logic                                unused_addr_bits;

  axi_lite_wr_capture #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wr_capture (
    .clk          (clk),
    .rst_n        (rst_n),
    .aw_addr      (aw_addr),
    .aw_valid     (aw_valid),
    .aw_ready     (aw_ready),
    .w_data       (w_data),
    .w_strb       (w_strb),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .b_valid      (b_valid),
    .clear        (commit),
    .both_captured(both_captured),
    .held_addr    (wr_addr),
    .held_data    (wr_data),
    .held_strb    (wr_strb)
  );

  // Upper address bits were already decoded by the bridge.
  assign unused_addr_bits = ^{wr_addr, ar_addr};

  assign wr_idx      = wr_addr[ByteShift +: IdxW];
  assign rd_idx      = ar_addr[ByteShift +: IdxW];
  assign wr_in_range = wr_idx < IdxW'(NUM_REGS);
  assign rd_in_range = rd_idx < IdxW'(NUM_REGS);

  // Write FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state_q <= WIdle;
    else        w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (both_captured) w_state_d = WCommit;
      WCommit: w_state_d = WResp;
      WResp:   if (b_ready) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_comb begin
    commit  = (w_state_q == WCommit);
    b_valid = (w_state_q == WResp);
  end

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    if (commit) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IdxW'(i)) begin
          pulse_d[i] = 1'b1;
          for (int unsigned b = 0; b < StrbW; b++) begin
            if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= {NUM_REGS{RESET_VAL}};
      pulse_q  <= '0;
      b_resp_q <= RESP_OKAY;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
      if (commit) b_resp_q <= wr_in_range ? RESP_OKAY : RangeErrResp;
    end
  end

  assign reg_q        = regs_q;
  assign reg_wr_pulse = pulse_q;
  assign b_resp       = b_resp_q;

  // Read FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state_q <= RIdle;
    else        r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_valid) r_state_d = RResp;
      RResp:   if (r_ready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    ar_ready = (r_state_q == RIdle);
    r_valid  = (r_state_q == RResp);
  end

  assign ar_fire = ar_valid && ar_ready;

  // Out-of-range indices match no register and read as zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IdxW'(i)) rd_word = regs_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else if (ar_fire) begin
      r_data_q <= rd_word;
      r_resp_q <= rd_in_range ? RESP_OKAY : RangeErrResp;
    end
  end

  assign r_data = r_data_q;
  assign r_resp = r_resp_q;

endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

Memory-mapped register-file slave that sits directly downstream of the 1×M AXI-Lite bridge, one instance per bridge slave port. It terminates the AXI-Lite protocol and exposes NUM_REGS control registers to hardware, with per-register write pulses. It accepts AW and W in either order, applies byte strobes, and returns one response per transaction. Out-of-range offsets are flagged, not silently dropped.

## Interface
- NUM_REGS, 8: number of registers; must be ≥1.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, 32: data width; 32 or 64 only.
- RESET_VAL, '0: reset value loaded into every register.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- aw_addr / aw_valid / aw_ready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- w_data / w_strb / w_valid / w_ready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- b_resp / b_valid / b_ready  out/out/in  2/1/1  write response channel.
- ar_addr / ar_valid / ar_ready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- r_data / r_resp / r_valid / r_ready  out/out/out/in  DATA_WIDTH/2/1/1  read data channel.
- reg_q  out  NUM_REGS×DATA_WIDTH  current register contents, packed, reg 0 in the LSBs.
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after a register commits.

## Operation
- Byte address to index: idx = aw_addr >> log2(DATA_WIDTH/8). Low byte-offset bits are ignored. Bits above the index field are ignored, because the bridge has already decoded the window.
- idx ≥ NUM_REGS is out of range.
- Write path, states W_IDLE → W_COMMIT → W_RESP:
  - AW and W are captured into independent hold registers (aw_held, w_held).
  - aw_ready = !aw_held && !b_valid; w_ready = !w_held && !b_valid.
  - When both holds are set, the FSM enters W_COMMIT. The commit updates the selected bytes (w_strb[k] set → byte k replaced), clears both holds, pulses reg_wr_pulse[idx], and moves to W_RESP with b_valid=1.
  - b_valid is held with b_resp stable until b_ready; then W_IDLE.
  - Out-of-range commit: no register changes and no pulse.
  - A commit with w_strb == 0 changes no register, still pulses, and returns OKAY.
- Read path, states R_IDLE → R_RESP:
  - ar_ready = !r_valid.
  - On the AR handshake, r_data and r_resp are registered and r_valid=1.
  - r_data, r_resp and r_valid are held until r_ready.
  - Out-of-range read: r_data = 0.
- The read and write paths are fully independent; both can be active in the same cycle.
- Same-edge AR capture and write commit to the same index: the read returns the pre-commit value.
- Reset (asynchronous, mid-transaction included):
  - All registers → RESET_VAL; holds cleared.
  - b_valid=0, r_valid=0, r_data=0, b_resp=0, r_resp=0, reg_wr_pulse=0.
  - aw_ready=w_ready=ar_ready=1 after reset.
  - Any in-flight transaction is discarded.

## Timing
- Write, AW and W handshaking in the same cycle T: hold registers set at the edge ending T; commit at the edge ending T+1; b_valid=1 and reg_q updated in T+2; reg_wr_pulse high in T+2 only.
- Write with AW and W separated: T is the cycle of the later handshake.
- Write throughput: one write per 3 cycles with b_ready held high. A new AW/W is accepted in the cycle after the B handshake.
- Read: AR handshake in T → r_valid in T+1. Throughput is one read per 2 cycles with r_ready held high.
- All outputs are registered except the ready signals, which are combinational from state only and do not depend on any valid input.

## Configuration
- AXIL_SLV_SLVERR_EN defined: out-of-range accesses return SLVERR (2'b10) on B or R.
- AXIL_SLV_SLVERR_EN undefined: out-of-range accesses return OKAY. Reads return 0; writes are dropped.
- In-range accesses return OKAY in both builds.

## Structure
- The shared package axi_lite_pkg holds RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and RESP_DECERR=2'b11, plus the write/read FSM state enums. The bridge uses the same response constants.
- One sub-module, axi_lite_wr_capture, is natural. It owns the AW/W hold registers and the ready generation, and outputs a both-held indication with the captured address, data and strobe.
- Register storage, commit logic and the read path stay in the top module.

## Test plan
- Reset, then read idx 3 (ar_addr=0x0C) → r_data=RESET_VAL, r_resp=OKAY, r_valid in the cycle after the AR handshake.
- Write 0xDEADBEEF to 0x04 with strb=0xF, AW and W in the same cycle, b_ready high → b_valid two cycles later; reg_wr_pulse[1] for one cycle; reg_q[1]=0xDEADBEEF.
- W sent 3 cycles before AW, strb=0x3, data 0x0000_1234 to reg 1 holding 0xDEADBEEF → reg_q[1]=0xDEAD1234; exactly one B response.
- b_ready held low for 5 cycles → b_valid and b_resp stable; aw_ready and w_ready stay 0 until the B handshake.
- Access 0x20 with NUM_REGS=8 → SLVERR with the macro defined, OKAY/0 without it; no register changes and no pulse in either build.
- Read and write to reg 2 committing on the same edge → read returns the old value; a following read returns the new value.
- Assert rst_n while b_valid=1 → b_valid=0 immediately; registers return to RESET_VAL; the next transaction completes normally.
